// File: rtl/dtc_therm_accum.sv
// dtc_therm_accum: windowed accumulator of thermometer-coded class levels with valid/ready result.
// Define DTC_THERM_CHECK_EN for first-zero level decoding and malformed-code counting.
module dtc_therm_accum #(
  parameter int LOG2_WIN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            inp,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [3+LOG2_WIN:0]   outp_sum,
  output logic [3:0]            outp_mean,
  output logic [LOG2_WIN:0]     outp_err,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int SW = 4 + LOG2_WIN;
  localparam int EW = LOG2_WIN + 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t              state_q;
  logic [SW-1:0]       acc_q, acc_d, sum_q, sum_d;
  logic [EW-1:0]       errc_q, errc_d, err_q, err_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [3:0]          lvl, mean_q, mean_d;
  logic [SW:0]         rnd;
  logic                bad, take, done;
`ifdef DTC_THERM_CHECK_EN
  // descending scan leaves the lowest zero index; any one at or above it marks a malformed code
  always_comb begin
    lvl = 4'd10;
    for (int i = 9; i >= 0; i--) if (!inp[i]) lvl = 4'(i);
    bad = |(inp >> lvl);
  end
`else
  always_comb begin
    lvl = '0;
    for (int i = 0; i < 10; i++) lvl = lvl + 4'(inp[i]);
    bad = 1'b0;
  end
`endif
  assign in_ready  = state_q == ACCUM || out_ready;
  assign out_valid = state_q == HOLD;
  assign take      = in_valid && in_ready && !flush;
  assign done      = take && &cnt_q;
  assign outp_sum  = sum_q;
  assign outp_mean = mean_q;
  assign outp_err  = err_q;
  always_comb begin
    sum_d  = acc_q + SW'(lvl);
    err_d  = errc_q + EW'(bad);
    rnd    = {1'b0, sum_d} + (SW+1)'(1 << (LOG2_WIN - 1));
    mean_d = 4'(rnd >> LOG2_WIN);
    acc_d  = (flush || done) ? '0 : take ? sum_d : acc_q;
    errc_d = (flush || done) ? '0 : take ? err_d : errc_q;
    cnt_d  = (flush || done) ? '0 : take ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      errc_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= '0;
      mean_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      errc_q <= errc_d;
      cnt_q  <= cnt_d;
      if (done) begin
        sum_q   <= sum_d;
        err_q   <= err_d;
        mean_q  <= mean_d;
        state_q <= HOLD;
      end else if (out_valid && out_ready) state_q <= ACCUM;
    end
  end
endmodule

// File: tb/tb_dtc_therm_accum.sv
// tb_dtc_therm_accum: directed and random stimulus against a window-level reference model.
module tb_dtc_therm_accum;
  localparam int L = 3;
  localparam int W = 1 << L;
  logic           clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [9:0]     inp = '0;
  logic           in_ready, out_valid;
  logic [3+L:0]   outp_sum;
  logic [3:0]     outp_mean;
  logic [L:0]     outp_err;
  int tests = 0, fails = 0;
  int m_ov, m_sum, m_mean, m_err, m_acc, m_errs, m_cnt;

  dtc_therm_accum #(.LOG2_WIN(L)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .outp_sum(outp_sum), .outp_mean(outp_mean), .outp_err(outp_err),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_level(input logic [9:0] v, output int lv, output int bad);
`ifdef DTC_THERM_CHECK_EN
    lv = 0;
    while (lv < 10 && v[lv]) lv++;
    bad = ($countones(v) != lv) ? 1 : 0;
`else
    lv = $countones(v);
    bad = 0;
`endif
  endtask

  task automatic model_reset();
    m_ov = 0; m_sum = 0; m_mean = 0; m_err = 0; m_acc = 0; m_errs = 0; m_cnt = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), m_ov);
    chk({tag, "_sum"}, 32'(outp_sum), m_sum);
    chk({tag, "_mean"}, 32'(outp_mean), m_mean);
    chk({tag, "_err"}, 32'(outp_err), m_err);
    chk({tag, "_ird"}, 32'(in_ready), (!m_ov || out_ready) ? 1 : 0);
  endtask

  // one clock: drive, predict, step, compare
  task automatic cycle(input logic [9:0] v, input logic iv, input logic ordy, input logic fl, input string tag);
    int lv, bad, done;
    inp = v; in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    chk({tag, "_ird_pre"}, 32'(in_ready), (!m_ov || ordy) ? 1 : 0);
    done = 0;
    if (fl) begin
      m_acc = 0; m_errs = 0; m_cnt = 0;
    end else if (iv && (!m_ov || ordy)) begin
      model_level(v, lv, bad);
      m_acc += lv; m_errs += bad; m_cnt++;
      if (m_cnt == W) begin
        m_sum = m_acc; m_err = m_errs; m_mean = (m_acc + W / 2) / W;
        m_acc = 0; m_errs = 0; m_cnt = 0; m_ov = 1; done = 1;
      end
    end
    if (!done && m_ov && ordy) m_ov = 0;
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk({tag, "_ov"}, 32'(out_valid), 0);
    chk({tag, "_sum"}, 32'(outp_sum), 0);
    chk({tag, "_mean"}, 32'(outp_mean), 0);
    chk({tag, "_err"}, 32'(outp_err), 0);
    chk({tag, "_ird"}, 32'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    check_outs("reset");
    for (int i = 0; i < W; i++) cycle(10'b0000111111, 1, 1, 0, "w48");
    chk("plan_sum48", 32'(outp_sum), 48);
    chk("plan_mean6", 32'(outp_mean), 6);
    for (int i = 0; i < W - 1; i++) cycle(10'b0000000111, 1, 1, 0, "w25");
    cycle(10'b0000001111, 1, 1, 0, "w25");
    chk("plan_sum25", 32'(outp_sum), 25);
    chk("plan_mean3", 32'(outp_mean), 3);
    for (int i = 0; i < W; i++) cycle(10'b1111111111, 1, 1, 0, "w80");
    chk("plan_sum80", 32'(outp_sum), 80);
    chk("plan_mean10", 32'(outp_mean), 10);
    for (int i = 0; i < W; i++) cycle(10'b0000101111, 1, 1, 0, "wbad");
`ifdef DTC_THERM_CHECK_EN
    chk("plan_bad_sum", 32'(outp_sum), 32);
    chk("plan_bad_err", 32'(outp_err), 8);
`else
    chk("plan_bad_sum", 32'(outp_sum), 40);
    chk("plan_bad_err", 32'(outp_err), 0);
`endif
    cycle(10'b0, 0, 1, 0, "drain");
    for (int i = 0; i < W; i++) cycle(10'b0000000011, 1, 0, 0, "bp_fill");
    for (int i = 0; i < 3; i++) cycle(10'b0000000001, 1, 0, 0, "bp_hold");
    chk("plan_bp_sum", 32'(outp_sum), 16);
    chk("plan_bp_ov", 32'(out_valid), 1);
    for (int i = 0; i < W; i++) cycle(10'b0000000001, 1, 1, 0, "bp_release");
    chk("plan_bp2_sum", 32'(outp_sum), 8);
    for (int i = 0; i < 5; i++) cycle(10'b1111111111, 1, 1, 0, "fl_pre");
    cycle(10'b1111111111, 1, 1, 1, "fl");
    for (int i = 0; i < W; i++) cycle(10'b0000011111, 1, 1, 0, "fl_post");
    chk("plan_fl_sum", 32'(outp_sum), 40);
    chk("plan_fl_mean", 32'(outp_mean), 5);
    cycle(10'b0, 0, 1, 0, "drain2");
    for (int i = 0; i < 4; i++) cycle(10'b0000000111, 1, 1, 0, "rst_a_pre");
    async_reset("rst_mid");
    for (int i = 0; i < W - 1; i++) cycle(10'b0000000001, 1, 1, 0, "rst_a_post");
    chk("plan_rst_no_early", 32'(out_valid), 0);
    cycle(10'b0000000001, 1, 0, 0, "rst_a_post");
    chk("plan_rst_sum8", 32'(outp_sum), 8);
    async_reset("rst_hold");
    for (int i = 0; i < 400; i++) begin
      logic [9:0] v;
      v = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'((1 << $urandom_range(0, 10)) - 1);
      cycle(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
